// File: rtl/zigbee_chip_spreader_pkg.sv
// Shared types and the 802.15.4 2.4 GHz chip table for the DSSS spreader.
// Chip vectors use bit index = chip index, so c0 is bit 0.
package zigbee_pkg;

   typedef logic [3:0] sym_t;
   typedef logic [4:0] chip_cnt_t;

   typedef enum logic {
      IDLE,
      SHIFT
   } spr_state_t;

   localparam logic [31:0] S0_CHIPS      = 32'h744AC39B;
   localparam logic [31:0] ODD_CHIP_MASK = 32'hAAAAAAAA;

   localparam logic [31:0] CHIP_TABLE [16] = '{
      32'h744AC39B, 32'h44AC39B7, 32'h4AC39B74, 32'hAC39B744,
      32'hC39B744A, 32'h39B744AC, 32'h9B744AC3, 32'hB744AC39,
      32'hDEE06931, 32'hEE06931D, 32'hE06931DE, 32'h06931DEE,
      32'h6931DEE0, 32'h931DEE06, 32'h31DEE069, 32'h1DEE0693
   };

endpackage

// File: rtl/zigbee_chip_spreader_if.sv
// Symbol-in / chip-out handshake bundle of the DSSS spreader.
interface zigbee_chip_spreader_if;
   import zigbee_pkg::*;

   sym_t inSymbol;
   logic inSymbolValid;
   logic outSymbolReady;
   logic outChip;
   logic outChipValid;
   logic inChipReady;
   logic outSymStart;
   logic outSymEnd;
   logic outBusy;
   logic outUnderrun;

   modport master (
      output inSymbol, inSymbolValid, inChipReady,
      input  outSymbolReady, outChip, outChipValid, outSymStart, outSymEnd,
             outBusy, outUnderrun
   );

   modport slave (
      input  inSymbol, inSymbolValid, inChipReady,
      output outSymbolReady, outChip, outChipValid, outSymStart, outSymEnd,
             outBusy, outUnderrun
   );

endinterface

// File: rtl/zigbee_chip_spreader_lut.sv
// Symbol -> 32-chip PN vector, built from S0 by 4-chip rotation and odd-chip inversion.
module zigbee_chip_lut
   import zigbee_pkg::*;
(
   input  sym_t        sym,
   output logic [31:0] chips
);

   logic [4:0]  rotAmt;
   logic [31:0] base;

   // Rotating the chip sequence right by 4 positions moves chip i to bit i+4.
   always_comb begin
      rotAmt = {sym[2:0], 2'b00};
      base   = (S0_CHIPS << rotAmt) | (S0_CHIPS >> (6'd32 - {1'b0, rotAmt}));
      chips  = sym[3] ? (base ^ ODD_CHIP_MASK) : base;
      assert (chips == CHIP_TABLE[sym]);
   end

endmodule

// File: rtl/zigbee_chip_spreader.sv
// 802.15.4 O-QPSK DSSS spreader: 4-bit symbols in, serial chips out (c0 first),
// with a one-entry holding buffer so consecutive symbols stream without bubbles.
module zigbee_chip_spreader
   import zigbee_pkg::*;
#(
   parameter int unsigned CHIPS_PER_SYM = 32,
   parameter int unsigned SYM_W         = 4
) (
   input logic                   inClock,
   input logic                   inReset,
   zigbee_chip_spreader_if.slave bus
);

   spr_state_t             state, stateNext;
   chip_cnt_t              cnt, cntNext;
   sym_t                   symReg, symNext;
   logic [SYM_W-1:0]       holdReg, holdNext;
   logic                   holdFull, holdFullNext;
   logic                   armed, armedNext;
   logic                   underrun, underrunNext;
   logic [CHIPS_PER_SYM-1:0] chipVec;
   logic                   symXfer, chipXfer, lastChip;

   zigbee_chip_lut uLut (
      .sym   (symReg),
      .chips (chipVec)
   );

   assign symXfer  = bus.inSymbolValid && !holdFull;
   assign chipXfer = (state == SHIFT) && bus.inChipReady;
   assign lastChip = (cnt == chip_cnt_t'(CHIPS_PER_SYM - 1));

   always_ff @(posedge inClock or posedge inReset) begin
      if (inReset) begin
         state    <= IDLE;
         cnt      <= '0;
         symReg   <= '0;
         holdReg  <= '0;
         holdFull <= 1'b0;
         armed    <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         symReg   <= symNext;
         holdReg  <= holdNext;
         holdFull <= holdFullNext;
         armed    <= armedNext;
         underrun <= underrunNext;
      end
   end

   always_comb begin
      stateNext    = state;
      cntNext      = cnt;
      symNext      = symReg;
      holdNext     = holdReg;
      holdFullNext = holdFull;
      armedNext    = armed || symXfer;
      underrunNext = 1'b0;

      case (state)
         IDLE: begin
            armedNext = symXfer;
            if (symXfer) begin
               stateNext = SHIFT;
               symNext   = bus.inSymbol;
               cntNext   = '0;
            end
         end
         SHIFT: begin
            if (chipXfer) begin
               cntNext = cnt + 5'd1;
            end
            // At the wrap the held symbol wins; ready is low whenever it is full,
            // so a same-cycle input transfer only happens with the buffer empty.
            if (chipXfer && lastChip) begin
               if (holdFull) begin
                  symNext      = holdReg;
                  holdFullNext = 1'b0;
               end else if (symXfer) begin
                  symNext = bus.inSymbol;
               end else begin
                  stateNext    = IDLE;
                  underrunNext = armed && !bus.inSymbolValid;
               end
            end else if (symXfer) begin
               holdNext     = bus.inSymbol;
               holdFullNext = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign bus.outSymbolReady = !holdFull;
   assign bus.outChipValid   = (state == SHIFT);
   assign bus.outChip        = (state == SHIFT) && chipVec[cnt];
   assign bus.outSymStart    = (state == SHIFT) && (cnt == '0);
   assign bus.outSymEnd      = (state == SHIFT) && lastChip;
   assign bus.outBusy        = (state == SHIFT) || holdFull;
   assign bus.outUnderrun    = underrun;

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Self-checking bench for zigbee_chip_spreader: scoreboard of expected chips
// filled on symbol acceptance and consumed by a negedge chip monitor.
module tb_zigbee_chip_spreader;
   import zigbee_pkg::*;

   typedef struct packed {
      logic chip;
      logic first;
      logic last;
   } exp_t;

   // MSB = chip c0, written exactly as the chip sequences read left to right
   localparam logic [31:0] S0_SPEC = 32'b11011001110000110101001000101110;
   localparam logic [31:0] S1_SPEC = 32'b11101101100111000011010100100010;
   localparam logic [31:0] S8_SPEC = 32'b10001100100101100000011101111011;

   logic inClock = 1'b0;
   logic inReset = 1'b0;

   zigbee_chip_spreader_if bus ();

   zigbee_chip_spreader #(
      .CHIPS_PER_SYM (32),
      .SYM_W         (4)
   ) dut (
      .inClock (inClock),
      .inReset (inReset),
      .bus     (bus)
   );

   always #5 inClock = ~inClock;

   exp_t expQ[$];
   int   checks = 0;
   int   passes = 0;
   int   underrunSeen = 0;
   int   startSeen = 0;
   int   endSeen = 0;
   int   popCount = 0;
   int   bubbles = 0;
   int   waitCycles = 0;
   bit   gapWatch = 1'b0;

   function automatic logic [31:0] modelVec(input int unsigned s);
      logic [31:0] s0;
      logic [31:0] v;
      s0 = S0_SPEC;
      for (int unsigned k = 0; k < 32; k++) begin
         int unsigned idx;
         idx = (k + 32 - 4 * (s % 8)) % 32;
         v[31-k] = s0[31-idx] ^ ((s >= 8) && (k % 2 == 1));
      end
      return v;
   endfunction

   function automatic logic [31:0] pkgVec(input int unsigned s);
      logic [31:0] t;
      logic [31:0] v;
      t = CHIP_TABLE[s];
      for (int unsigned k = 0; k < 32; k++) v[31-k] = t[k];
      return v;
   endfunction

   task automatic pushChips(input logic [31:0] v);
      for (int unsigned k = 0; k < 32; k++) begin
         exp_t e;
         e.chip  = v[31-k];
         e.first = (k == 0);
         e.last  = (k == 31);
         expQ.push_back(e);
      end
   endtask

   always @(negedge inClock) begin : monitor
      exp_t e;
      if (bus.outUnderrun === 1'b1) underrunSeen++;
      if (gapWatch && bus.outChipValid !== 1'b1) bubbles++;
      if (bus.outChipValid === 1'b1) begin
         checks++;
         if (expQ.size() == 0) begin
            $display("FAIL unexpectedChip: outChipValid=%b required 0 (no chip pending)", bus.outChipValid);
         end else begin
            e = expQ[0];
            if (bus.outChip !== e.chip || bus.outSymStart !== e.first || bus.outSymEnd !== e.last)
               $display("FAIL chipStream: chip/start/end=%b%b%b required %b%b%b after %0d chips",
                        bus.outChip, bus.outSymStart, bus.outSymEnd, e.chip, e.first, e.last, popCount);
            else
               passes++;
            if (bus.inChipReady === 1'b1) begin
               void'(expQ.pop_front());
               popCount++;
               if (e.first) startSeen++;
               if (e.last) endSeen++;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the symbol transfer.
   task automatic sendSym(input logic [3:0] s, input logic [31:0] v);
      int n;
      n = 0;
      bus.inSymbol      = s;
      bus.inSymbolValid = 1'b1;
      @(negedge inClock);
      while (bus.outSymbolReady !== 1'b1 && n < 200) begin
         n++;
         waitCycles++;
         @(negedge inClock);
      end
      if (bus.outSymbolReady !== 1'b1) begin
         checks++;
         $display("FAIL symAccept: outSymbolReady=%b required 1 within 200 cycles", bus.outSymbolReady);
      end else begin
         pushChips(v);
      end
      @(posedge inClock);
      #1;
      bus.inSymbolValid = 1'b0;
      bus.inSymbol      = 'x;
   endtask

   task automatic drain(input int limit, output int n);
      n = 0;
      while (expQ.size() != 0 && n < limit) begin
         @(posedge inClock);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      logic [6:0] obs;
      #1 inReset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.inSymbol      = 4'($urandom);
         bus.inSymbolValid = 1'($urandom);
         bus.inChipReady   = 1'($urandom);
         @(negedge inClock);
         obs = {bus.outChip, bus.outChipValid, bus.outSymStart, bus.outSymEnd,
                bus.outBusy, bus.outUnderrun, bus.outSymbolReady};
         checks++;
         if (obs !== 7'b0000001)
            $display("FAIL resetOutputs: chip,valid,start,end,busy,underrun,ready=%b required 0000001", obs);
         else
            passes++;
      end
      bus.inSymbolValid = 1'b0;
      bus.inSymbol      = 'x;
      bus.inChipReady   = 1'b1;
      @(posedge inClock);
      #1 inReset = 1'b0;
      @(posedge inClock);
      #1;
   endtask

   task automatic test_single();
      logic [31:0] v0;
      int n;
      int u0;
      v0 = S0_SPEC;
      u0 = underrunSeen;
      bus.inChipReady = 1'b1;
      sendSym(4'h0, S0_SPEC);
      checks++;
      if (bus.outChipValid !== 1'b1 || bus.outSymStart !== 1'b1 || bus.outChip !== v0[31])
         $display("FAIL firstChipLatency: valid/start/chip=%b%b%b required 11%b",
                  bus.outChipValid, bus.outSymStart, bus.outChip, v0[31]);
      else
         passes++;
      drain(100, n);
      checks++;
      if (n !== 32) $display("FAIL singleChipCycles: cycles=%0d required 32", n);
      else passes++;
      @(posedge inClock);
      #1;
      @(posedge inClock);
      #1;
      checks++;
      if (bus.outChipValid !== 1'b0 || bus.outBusy !== 1'b0)
         $display("FAIL singleIdle: valid/busy=%b%b required 00", bus.outChipValid, bus.outBusy);
      else
         passes++;
      checks++;
      if (underrunSeen - u0 !== 1) $display("FAIL singleUnderrun: pulses=%0d required 1", underrunSeen - u0);
      else passes++;
   endtask

   task automatic test_back_to_back();
      int n;
      bus.inChipReady = 1'b1;
      waitCycles = 0;
      bubbles    = 0;
      sendSym(4'h1, S1_SPEC);
      gapWatch = 1'b1;
      sendSym(4'h8, S8_SPEC);
      sendSym(4'hF, modelVec(15));
      checks++;
      if (bus.outBusy !== 1'b1) $display("FAIL b2bBusy: outBusy=%b required 1", bus.outBusy);
      else passes++;
      drain(200, n);
      gapWatch = 1'b0;
      checks++;
      if (expQ.size() != 0) $display("FAIL b2bDrain: pending=%0d required 0", expQ.size());
      else passes++;
      checks++;
      if (bubbles !== 0) $display("FAIL b2bBubbles: bubbles=%0d required 0", bubbles);
      else passes++;
      checks++;
      if (waitCycles == 0) $display("FAIL b2bReadyDrop: notReadyCycles=%0d required >0", waitCycles);
      else passes++;
      @(posedge inClock);
      #1;
   endtask

   task automatic test_backpressure();
      int n;
      int p0;
      p0 = popCount;
      bus.inChipReady = 1'b0;
      sendSym(4'h5, modelVec(5));
      n = 0;
      while (expQ.size() != 0 && n < 3000) begin
         bus.inChipReady = ($urandom_range(0, 99) < 30);
         @(posedge inClock);
         #1;
         n++;
      end
      bus.inChipReady = 1'b1;
      checks++;
      if (popCount - p0 !== 32) $display("FAIL bpChipCount: chips=%0d required 32", popCount - p0);
      else passes++;
      @(posedge inClock);
      #1;
   endtask

   task automatic test_all_symbols();
      int n;
      int p0;
      int s0;
      int e0;
      p0 = popCount;
      s0 = startSeen;
      e0 = endSeen;
      bus.inChipReady = 1'b1;
      for (int unsigned s = 0; s < 16; s++) sendSym(4'(s), pkgVec(s));
      drain(400, n);
      checks++;
      if (popCount - p0 !== 512) $display("FAIL allChips: chips=%0d required 512", popCount - p0);
      else passes++;
      checks++;
      if (startSeen - s0 !== 16) $display("FAIL allStarts: starts=%0d required 16", startSeen - s0);
      else passes++;
      checks++;
      if (endSeen - e0 !== 16) $display("FAIL allEnds: ends=%0d required 16", endSeen - e0);
      else passes++;
      @(posedge inClock);
      #1;
   endtask

   task automatic test_wrap_join();
      int n;
      int u0;
      logic [31:0] va;
      u0 = underrunSeen;
      va = modelVec(10);
      bus.inChipReady = 1'b1;
      sendSym(4'h3, modelVec(3));
      n = 0;
      while (bus.outSymEnd !== 1'b1 && n < 100) begin
         @(posedge inClock);
         #1;
         n++;
      end
      checks++;
      if (bus.outSymEnd !== 1'b1 || bus.outSymbolReady !== 1'b1)
         $display("FAIL joinSetup: end/ready=%b%b required 11", bus.outSymEnd, bus.outSymbolReady);
      else
         passes++;
      bus.inSymbol      = 4'hA;
      bus.inSymbolValid = 1'b1;
      pushChips(va);
      @(posedge inClock);
      #1;
      bus.inSymbolValid = 1'b0;
      bus.inSymbol      = 'x;
      checks++;
      if (bus.outChipValid !== 1'b1 || bus.outSymStart !== 1'b1 || bus.outChip !== va[31])
         $display("FAIL joinNoBubble: valid/start/chip=%b%b%b required 11%b",
                  bus.outChipValid, bus.outSymStart, bus.outChip, va[31]);
      else
         passes++;
      @(negedge inClock);
      checks++;
      if (underrunSeen !== u0) $display("FAIL joinUnderrun: pulses=%0d required 0", underrunSeen - u0);
      else passes++;
      @(posedge inClock);
      #1;
      drain(100, n);
      @(posedge inClock);
      #1;
      @(posedge inClock);
      #1;
      checks++;
      if (underrunSeen - u0 !== 1) $display("FAIL joinEndUnderrun: pulses=%0d required 1", underrunSeen - u0);
      else passes++;
   endtask

   task automatic test_reset_mid();
      int bad;
      bus.inChipReady = 1'b1;
      sendSym(4'h6, modelVec(6));
      for (int i = 0; i < 10; i++) begin
         @(posedge inClock);
         #1;
      end
      #1 inReset = 1'b1;
      #1;
      checks++;
      if (bus.outChipValid !== 1'b0 || bus.outBusy !== 1'b0 || bus.outSymbolReady !== 1'b1)
         $display("FAIL midReset: valid/busy/ready=%b%b%b required 001",
                  bus.outChipValid, bus.outBusy, bus.outSymbolReady);
      else
         passes++;
      expQ.delete();
      @(posedge inClock);
      #1 inReset = 1'b0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge inClock);
         if (bus.outChipValid !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL postResetChips: validCycles=%0d required 0", bad);
      else passes++;
   endtask

   initial begin
      bus.inSymbol      = '0;
      bus.inSymbolValid = 1'b0;
      bus.inChipReady   = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_all_symbols();
      test_wrap_join();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passes, checks);
      $fatal(1);
   end

endmodule
